servo_motion_sequencer: RTL
===========================

Name: servo_motion_sequencer

Overview:
Frame-synchronous position controller for the servo PWM datapath (frame counter plus on-time comparator). It accepts target pulse widths over a valid/ready handshake and owns the 20 ms frame timing. Each frame it slews the commanded pulse width toward the target by a bounded step, then drives on-time and cycle-time (in clocks) to the PWM generator. It sits between key/CPU command logic and the PWM generator.

Parameters:
CLK_PER_US, 50, clocks per microsecond (50 MHz)
FRAME_US, 20000, PWM frame length in us
MIN_US, 500, minimum legal pulse width in us
MAX_US, 2500, maximum legal pulse width in us
STEP_US, 10, maximum pulse-width change per frame in us
WDOG_FRAMES, 50, frames without a command before fault (only with the optional feature)

Ports:
Main_clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  run frame timer and motion; 0 = freeze
cmd_valid  in  1  target command valid
cmd_ready  out  1  sequencer can accept a command
cmd_pos_us  in  16  target pulse width in us
on_ticks  out  32  pulse high time in clocks, to PWM comparator
cycle_ticks  out  32  FRAME_US*CLK_PER_US, constant, to PWM counter max
frame_start  out  1  one-cycle pulse at frame counter value 0
busy  out  1  state == RAMP or a pending command exists
at_target  out  1  current == target and no pending command
clamped  out  1  sticky: last accepted command was out of range and was clamped
fault  out  1  watchdog expired (tied 0 without the optional feature)

Behaviour:
- Reset values: cur_us = target_us = 1500 (CENTER_US), on_ticks = 1500*CLK_PER_US, frame counter = 0, pending empty, cmd_ready = 1, frame_start = 0, busy = 0, at_target = 1, clamped = 0, fault = 0, state = IDLE.
- Frame timer: counts 0..FRAME_US*CLK_PER_US-1 while enable = 1, then wraps to 0. frame_start = 1 in every enabled cycle where count == 0.
  - enable = 0: counter is forced to 0, no frame_start, cur_us and target_us hold.
  - The first enabled cycle after enable rises produces a frame_start.
- Command handshake: one-deep pending register. cmd_ready = !pending_valid. Transfer occurs when cmd_valid && cmd_ready.
  - The captured value is clamped to [MIN_US, MAX_US]. clamped is set on a clamped capture and cleared on an in-range capture.
  - Commands are accepted regardless of enable.
- At frame_start, both of these happen in the same cycle:
  (a) cur_us steps toward the pre-load target_us by min(STEP_US, |target-cur|);
  (b) if pending_valid: target_us <= pending, pending cleared (cmd_ready high next cycle).
  - Effect: a new target first moves cur_us at the second frame_start after acceptance.
- Simultaneous accept and frame_start with pending empty: the command goes to pending and is loaded at the next frame_start.
- on_ticks is registered as cur_us*CLK_PER_US (32-bit, no overflow at MAX_US) and updates the cycle after frame_start. The PWM generator latches it on the following frame_start.
- FSM:
  - IDLE (cur == target) -> RAMP at a frame_start load that makes target != cur.
  - RAMP -> IDLE when a step makes cur == target.
  - FAULT exists only with the optional feature.
- Reset asserted mid-ramp: all state returns to reset values asynchronously. Any pending command is discarded.

Optional Feature:
SERVO_SEQ_WDOG_EN:
- Defined: a frame counter of frames since the last accepted command. On reaching WDOG_FRAMES, fault = 1, target_us forced to 1500, state = FAULT, and ramping toward center proceeds normally.
  - fault clears and the FSM returns to RAMP/IDLE on the next accepted command.
- Undefined: no watchdog logic, fault tied 0, FAULT state absent.

Decomposition:
- Package servo_pkg: CENTER_US = 1500, default timing constants, state enum (IDLE, RAMP, FAULT), 16-bit us type.
- Sub-module servo_frame_timer: frame counter plus frame_start generation, reusable by the PWM generator.

Test Plan:
Sim parameters: CLK_PER_US = 1, FRAME_US = 100, STEP_US = 100.
1. Reset release -> on_ticks = 1500, cycle_ticks = 100, at_target = 1, frame_start every 100 cycles starting at the first enabled cycle.
2. Command 2000 accepted -> loaded at F1; on_ticks goes 1600, 1700, 1800, 1900, 2000 after F2..F6; at_target = 1 after F6; busy = 1 from acceptance until then.
3. Command 3000 -> clamped = 1, target = 2500. Then command 700 -> clamped = 0, target = 700.
4. Two back-to-back commands (1800, 1200) before a frame_start -> second held off by cmd_ready = 0 until the cycle after F1; targets are loaded in order.
5. Drop enable mid-ramp for 350 cycles -> no frame_start, on_ticks frozen; on re-enable, a frame_start occurs in the first cycle and ramping resumes.
6. SERVO_SEQ_WDOG_EN, WDOG_FRAMES = 3, at 2000 with no commands -> fault = 1 at the 3rd frame; on_ticks ramps to 1500; a new command clears fault.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the servo motion sequencer.
// SERVO_SEQ_WDOG_EN adds the FAULT state used by the command watchdog.
package servo_pkg;

    localparam int unsigned CENTER_US        = 1500;
    localparam int unsigned DEF_CLK_PER_US   = 50;
    localparam int unsigned DEF_FRAME_US     = 20000;
    localparam int unsigned DEF_MIN_US       = 500;
    localparam int unsigned DEF_MAX_US       = 2500;
    localparam int unsigned DEF_STEP_US      = 10;
    localparam int unsigned DEF_WDOG_FRAMES  = 50;

    typedef logic [15:0] us_t;

`ifdef SERVO_SEQ_WDOG_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RAMP = 2'd1, ST_FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RAMP = 2'd1} state_t;
`endif

    // Move cur toward tgt by at most step; never overshoots.
    function automatic us_t step_toward(input us_t cur, input us_t tgt, input us_t step);
        us_t res;
        res = cur;
        if (tgt > cur) begin
            res = ((tgt - cur) > step) ? (cur + step) : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > step) ? (cur - step) : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter 0..FRAME_TICKS-1 with a frame_start strobe at count 0.
// Disabling holds the counter at 0 so the first enabled cycle starts a frame.
module servo_frame_timer #(
    parameter int unsigned FRAME_TICKS = 1000000
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic enable,
    output logic frame_start
);

    logic [31:0] count;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == 32'(FRAME_TICKS - 1)) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign frame_start = rst_b && enable && (count == '0);

endmodule

// File: rtl/servo_motion_sequencer.sv
// Frame-synchronous servo position slewing with a one-deep command buffer.
// Define SERVO_SEQ_WDOG_EN to add the no-command watchdog (fault output).
//
// state    | meaning
// ST_IDLE  | commanded width equals target
// ST_RAMP  | stepping toward target once per frame
// ST_FAULT | watchdog expired, ramping to center until a new command
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
    parameter int unsigned FRAME_US   = DEF_FRAME_US,
    parameter int unsigned MIN_US     = DEF_MIN_US,
    parameter int unsigned MAX_US     = DEF_MAX_US,
    parameter int unsigned STEP_US    = DEF_STEP_US
`ifdef SERVO_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_FRAMES = DEF_WDOG_FRAMES
`endif
) (
    input  logic        Main_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_pos_us,
    output logic [31:0] on_ticks,
    output logic [31:0] cycle_ticks,
    output logic        frame_start,
    output logic        busy,
    output logic        at_target,
    output logic        clamped,
    output logic        fault
);

    localparam int unsigned FRAME_TICKS  = FRAME_US * CLK_PER_US;
    localparam us_t         MIN_V        = us_t'(MIN_US);
    localparam us_t         MAX_V        = us_t'(MAX_US);
    localparam us_t         STEP_V       = us_t'(STEP_US);
    localparam us_t         CENTER_V     = us_t'(CENTER_US);
    localparam logic [31:0] CENTER_TICKS = 32'(CENTER_US * CLK_PER_US);

    state_t      state_q, state_d;
    us_t         cur_q, cur_d;
    us_t         tgt_q, tgt_d;
    us_t         pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        clamped_q, clamped_d;
    logic [31:0] on_ticks_q, on_ticks_d;
    logic        accept;
    logic        cmd_lo, cmd_hi;
    us_t         cmd_sat;

`ifdef SERVO_SEQ_WDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        fault_q, fault_d;
`endif

    servo_frame_timer #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_frame_timer (
        .clk_sys    (Main_clock),
        .rst_b      (reset),
        .enable     (enable),
        .frame_start(frame_start)
    );

    assign accept  = cmd_valid && !pend_vld_q;
    assign cmd_lo  = cmd_pos_us < MIN_V;
    assign cmd_hi  = cmd_pos_us > MAX_V;
    assign cmd_sat = cmd_lo ? MIN_V : (cmd_hi ? MAX_V : cmd_pos_us);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clamped_d  = clamped_q;
        on_ticks_d = on_ticks_q;
`ifdef SERVO_SEQ_WDOG_EN
        wdog_d     = wdog_q;
        fault_d    = fault_q;
`endif

        if (accept) begin
            pend_d     = cmd_sat;
            pend_vld_d = 1'b1;
            clamped_d  = cmd_lo || cmd_hi;
        end

        // The step uses the target held before this frame's load, so a new
        // target first moves the output one frame after it is loaded.
        if (frame_start) begin
            cur_d      = step_toward(cur_q, tgt_q, STEP_V);
            on_ticks_d = 32'(cur_d) * 32'(CLK_PER_US);
            if (pend_vld_q) begin
                tgt_d      = pend_q;
                pend_vld_d = 1'b0;
            end
            state_d = (cur_d == tgt_d) ? ST_IDLE : ST_RAMP;
        end

`ifdef SERVO_SEQ_WDOG_EN
        if (frame_start && !fault_q && !accept) begin
            if (wdog_q == 16'(WDOG_FRAMES - 1)) begin
                fault_d = 1'b1;
                tgt_d   = CENTER_V;
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end
        if (fault_d) begin
            state_d = ST_FAULT;
        end
        if (accept) begin
            wdog_d  = '0;
            fault_d = 1'b0;
            state_d = (cur_d == tgt_d) ? ST_IDLE : ST_RAMP;
        end
`endif
    end

    always_ff @(posedge Main_clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= CENTER_V;
            tgt_q      <= CENTER_V;
            pend_q     <= CENTER_V;
            pend_vld_q <= 1'b0;
            clamped_q  <= 1'b0;
            on_ticks_q <= CENTER_TICKS;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clamped_q  <= clamped_d;
            on_ticks_q <= on_ticks_d;
        end
    end

`ifdef SERVO_SEQ_WDOG_EN
    always_ff @(posedge Main_clock or negedge reset) begin
        if (!reset) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign cmd_ready   = !pend_vld_q;
    assign on_ticks    = on_ticks_q;
    assign cycle_ticks = 32'(FRAME_TICKS);
    assign busy        = (state_q == ST_RAMP) || pend_vld_q;
    assign at_target   = (cur_q == tgt_q) && !pend_vld_q;
    assign clamped     = clamped_q;

endmodule
